// File: rtl/issue_sched_pkg.sv
// Shared definitions for the issue scheduler: register-id geometry,
// one-hot functional-unit selects and a small hazard helper.
package issue_sched_pkg;

  localparam int REG_W    = 6;
  localparam int FPR_BIT  = 5;
  localparam int NREG     = 64;
  localparam int NMOD_DEF = 9;

  localparam logic [NMOD_DEF-1:0] mod_b   = 9'b000000001;
  localparam logic [NMOD_DEF-1:0] mod_io  = 9'b000000010;
  localparam logic [NMOD_DEF-1:0] mod_mem = 9'b000000100;
  localparam logic [NMOD_DEF-1:0] mod_alu = 9'b000001000;
  localparam logic [NMOD_DEF-1:0] mod_mv  = 9'b000010000;
  localparam logic [NMOD_DEF-1:0] mod_fab = 9'b000100000;
  localparam logic [NMOD_DEF-1:0] mod_fml = 9'b001000000;
  localparam logic [NMOD_DEF-1:0] mod_fds = 9'b010000000;
  localparam logic [NMOD_DEF-1:0] mod_fet = 9'b100000000;

  // True when both ids name the same real register (id 0 means "no register").
  function automatic logic reg_hit(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
    return (a != '0) && (a == b);
  endfunction

endpackage

// File: rtl/issue_sched_if.sv
// Decode, issue and writeback signals of the issue scheduler.
// master = environment (decode/units), slave = scheduler.
interface issue_sched_if
  import issue_sched_pkg::*;
#(
  parameter int NMOD   = NMOD_DEF,
  parameter int INFO_W = 48
);
  logic [1:0]          in_vld;
  logic [2*REG_W-1:0]  in_ds;
  logic [2*REG_W-1:0]  in_dt;
  logic [2*REG_W-1:0]  in_dd;
  logic [2*NMOD-1:0]   in_mod;
  logic [2*INFO_W-1:0] in_info;
  logic                busy;
  logic [NMOD-1:0]     unit_rdy;
  logic                wb_vld;
  logic [REG_W-1:0]    wb_reg;
  logic                flush;
  logic                iss_vld;
  logic [NMOD-1:0]     iss_mod;
  logic [REG_W-1:0]    iss_ds;
  logic [REG_W-1:0]    iss_dt;
  logic [REG_W-1:0]    iss_dd;
  logic [INFO_W-1:0]   iss_info;
  logic                err;

  modport master (
    output in_vld, in_ds, in_dt, in_dd, in_mod, in_info, unit_rdy, wb_vld, wb_reg, flush,
    input  busy, iss_vld, iss_mod, iss_ds, iss_dt, iss_dd, iss_info, err
  );

  modport slave (
    input  in_vld, in_ds, in_dt, in_dd, in_mod, in_info, unit_rdy, wb_vld, wb_reg, flush,
    output busy, iss_vld, iss_mod, iss_ds, iss_dt, iss_dd, iss_info, err
  );
endinterface

// File: rtl/issue_sched_pick.sv
// Combinational readiness check and oldest-ready selection over the
// age-ordered wait buffer (entry 0 is the oldest).
module issue_sched_pick
  import issue_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int NMOD  = NMOD_DEF,
  parameter int CNT_W = $clog2(DEPTH + 1),
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [CNT_W-1:0] count,
  input  logic [REG_W-1:0] ds [DEPTH],
  input  logic [REG_W-1:0] dt [DEPTH],
  input  logic [REG_W-1:0] dd [DEPTH],
  input  logic [NMOD-1:0]  mod [DEPTH],
  input  logic [NMOD-1:0]  unit_rdy,
  input  logic [NREG-1:0]  board,
  output logic             pick_vld,
  output logic [IDX_W-1:0] pick_idx
);

  logic [DEPTH-1:0] rdy;

  // An entry is ready when its registers are free, its unit can take it, and no older entry conflicts (RAW/WAW/WAR).
  always_comb begin
    rdy = '0;
    for (int k = 0; k < DEPTH; k++) begin
      rdy[k] = (k < int'(count)) && !board[ds[k]] && !board[dt[k]] && !board[dd[k]] &&
               (|(unit_rdy & mod[k]));
      for (int j = 0; j < k; j++) begin
        if (reg_hit(dd[j], ds[k]) || reg_hit(dd[j], dt[k]) || reg_hit(dd[j], dd[k]) ||
            reg_hit(dd[k], ds[j]) || reg_hit(dd[k], dt[j]))
          rdy[k] = 1'b0;
      end
    end
  end

  // Lowest index wins, which is the oldest ready entry.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (rdy[k]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/issue_sched.sv
// In-order-age issue scheduler: shift-queue wait buffer, register
// scoreboard and a registered single-issue port.
// Optional feature: define ISSUE_SCHED_WB_BYPASS_EN to let a same-cycle
// writeback release waiting readers one cycle earlier.
module issue_sched
  import issue_sched_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int NMOD   = NMOD_DEF,
  parameter int INFO_W = 48
) (
  input  logic         clk,
  input  logic         rstn,
  issue_sched_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  logic [CNT_W-1:0]  count_q, count_d, base;
  logic [REG_W-1:0]  ds_q [DEPTH], ds_d [DEPTH];
  logic [REG_W-1:0]  dt_q [DEPTH], dt_d [DEPTH];
  logic [REG_W-1:0]  dd_q [DEPTH], dd_d [DEPTH];
  logic [NMOD-1:0]   mod_q [DEPTH], mod_d [DEPTH];
  logic [INFO_W-1:0] info_q [DEPTH], info_d [DEPTH];
  logic [NREG-1:0]   board_q, board_d, board_eff;
  logic              err_q, err_d;
  logic              iss_vld_q, iss_vld_d;
  logic [NMOD-1:0]   iss_mod_q, iss_mod_d;
  logic [REG_W-1:0]  iss_ds_q, iss_ds_d, iss_dt_q, iss_dt_d, iss_dd_q, iss_dd_d;
  logic [INFO_W-1:0] iss_info_q, iss_info_d;
  logic              busy, wb_clr, pick_vld;
  logic [IDX_W-1:0]  pick_idx;

  assign busy   = count_q > CNT_W'(DEPTH - 2);
  assign wb_clr = bus.wb_vld && (bus.wb_reg != '0);

  // Scoreboard view used for readiness; the bypass build treats a register being written back now as already free.
  always_comb begin
    board_eff = board_q;
`ifdef ISSUE_SCHED_WB_BYPASS_EN
    if (wb_clr) board_eff[bus.wb_reg] = 1'b0;
`endif
  end

  issue_sched_pick #(
    .DEPTH (DEPTH),
    .NMOD  (NMOD),
    .CNT_W (CNT_W),
    .IDX_W (IDX_W)
  ) u_pick (
    .count    (count_q),
    .ds       (ds_q),
    .dt       (dt_q),
    .dd       (dd_q),
    .mod      (mod_q),
    .unit_rdy (bus.unit_rdy),
    .board    (board_eff),
    .pick_vld (pick_vld),
    .pick_idx (pick_idx)
  );

  // Next state: writeback clears, issue removes the picked entry and sets its destination (set beats clear), decode appends behind.
  always_comb begin
    count_d    = count_q;
    base       = count_q;
    ds_d       = ds_q;
    dt_d       = dt_q;
    dd_d       = dd_q;
    mod_d      = mod_q;
    info_d     = info_q;
    board_d    = board_q;
    err_d      = err_q;
    iss_vld_d  = 1'b0;
    iss_mod_d  = '0;
    iss_ds_d   = '0;
    iss_dt_d   = '0;
    iss_dd_d   = '0;
    iss_info_d = '0;
    if (wb_clr) begin
      board_d[bus.wb_reg] = 1'b0;
      if (!board_q[bus.wb_reg]) err_d = 1'b1;
    end
    if (bus.flush) begin
      count_d = '0;
    end else begin
      if (pick_vld) begin
        iss_vld_d  = 1'b1;
        iss_mod_d  = mod_q[pick_idx];
        iss_ds_d   = ds_q[pick_idx];
        iss_dt_d   = dt_q[pick_idx];
        iss_dd_d   = dd_q[pick_idx];
        iss_info_d = info_q[pick_idx];
        if (dd_q[pick_idx] != '0) board_d[dd_q[pick_idx]] = 1'b1;
        for (int i = 0; i < DEPTH - 1; i++) begin
          if (i >= int'(pick_idx)) begin
            ds_d[i]   = ds_q[i+1];
            dt_d[i]   = dt_q[i+1];
            dd_d[i]   = dd_q[i+1];
            mod_d[i]  = mod_q[i+1];
            info_d[i] = info_q[i+1];
          end
        end
        base = count_q - CNT_W'(1);
      end
      if (!busy) begin
        for (int s = 0; s < 2; s++) begin
          if (bus.in_vld[s]) begin
            ds_d[IDX_W'(base)]   = bus.in_ds[s*REG_W +: REG_W];
            dt_d[IDX_W'(base)]   = bus.in_dt[s*REG_W +: REG_W];
            dd_d[IDX_W'(base)]   = bus.in_dd[s*REG_W +: REG_W];
            mod_d[IDX_W'(base)]  = bus.in_mod[s*NMOD +: NMOD];
            info_d[IDX_W'(base)] = bus.in_info[s*INFO_W +: INFO_W];
            base = base + CNT_W'(1);
          end
        end
      end
      count_d = base;
    end
  end

  // Control state: occupancy, scoreboard, sticky error and the issue register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_q    <= '0;
      board_q    <= '0;
      err_q      <= 1'b0;
      iss_vld_q  <= 1'b0;
      iss_mod_q  <= '0;
      iss_ds_q   <= '0;
      iss_dt_q   <= '0;
      iss_dd_q   <= '0;
      iss_info_q <= '0;
    end else begin
      count_q    <= count_d;
      board_q    <= board_d;
      err_q      <= err_d;
      iss_vld_q  <= iss_vld_d;
      iss_mod_q  <= iss_mod_d;
      iss_ds_q   <= iss_ds_d;
      iss_dt_q   <= iss_dt_d;
      iss_dd_q   <= iss_dd_d;
      iss_info_q <= iss_info_d;
    end
  end

  // Entry payloads need no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    ds_q   <= ds_d;
    dt_q   <= dt_d;
    dd_q   <= dd_d;
    mod_q  <= mod_d;
    info_q <= info_d;
  end

  assign bus.busy     = busy;
  assign bus.iss_vld  = iss_vld_q;
  assign bus.iss_mod  = iss_mod_q;
  assign bus.iss_ds   = iss_ds_q;
  assign bus.iss_dt   = iss_dt_q;
  assign bus.iss_dd   = iss_dd_q;
  assign bus.iss_info = iss_info_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_issue_sched.sv
// Testbench for issue_sched: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
// Honours ISSUE_SCHED_WB_BYPASS_EN when it is defined for the build.
module tb_issue_sched;
  import issue_sched_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [8:0] U = 9'h1FF;

  logic clk;
  logic rstn;
  int   tests;
  int   fails;

  issue_sched_if #(.NMOD(9), .INFO_W(48)) bus ();

  issue_sched #(.DEPTH(DEPTH), .NMOD(9), .INFO_W(48)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Free-running clock, rising edge every 10 time units
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  ds, dt, dd;
    logic [8:0]  mod;
    logic [47:0] info;
  } ent_t;

  typedef struct {
    logic [1:0] vld;
    logic [5:0] ds0, dt0, dd0, ds1, dt1, dd1;
    logic [8:0] mod0, mod1, urdy;
    logic       wb;
    logic [5:0] wbr;
    logic       e_iss;
    logic [5:0] e_dd;
    logic       e_err, e_busy;
  } vec_t;

  ent_t        mq[$];
  logic [63:0] mboard;
  logic        merr;
  logic        m_iss_vld;
  ent_t        m_iss;
  vec_t        tbl[18];
  logic [8:0]  mods[9];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic bit hit(input logic [5:0] a, input logic [5:0] b);
    return (a != 0) && (a == b);
  endfunction

  // An entry may go when nothing it touches is owed a writeback, its unit is free, and no older entry shares a hazard with it
  function automatic bit readyAt(input int k, input logic [63:0] eff);
    ent_t e;
    ent_t o;
    e = mq[k];
    if (eff[e.ds] || eff[e.dt] || eff[e.dd]) return 0;
    if ((bus.unit_rdy & e.mod) == 0) return 0;
    for (int j = 0; j < k; j++) begin
      o = mq[j];
      if (hit(o.dd, e.ds) || hit(o.dd, e.dt) || hit(o.dd, e.dd)) return 0;
      if (hit(e.dd, o.ds) || hit(e.dd, o.dt)) return 0;
    end
    return 1;
  endfunction

  task automatic modelReset();
    mq.delete();
    mboard    = '0;
    merr      = 1'b0;
    m_iss_vld = 1'b0;
    m_iss     = '{default: 0};
  endtask

  // Advance the reference model by one clock using the inputs currently on the bus
  task automatic modelStep();
    logic [63:0] eff;
    logic [63:0] nb;
    int          pick;
    bit          was_busy;
    ent_t        e;
    eff = mboard;
    nb  = mboard;
    if (bus.wb_vld && bus.wb_reg != 0) begin
`ifdef ISSUE_SCHED_WB_BYPASS_EN
      eff[bus.wb_reg] = 1'b0;
`endif
      nb[bus.wb_reg] = 1'b0;
      if (!mboard[bus.wb_reg]) merr = 1'b1;
    end
    pick = -1;
    foreach (mq[k]) if (pick < 0 && readyAt(k, eff)) pick = k;
    m_iss_vld = 1'b0;
    m_iss     = '{default: 0};
    was_busy  = mq.size() > DEPTH - 2;
    if (bus.flush) begin
      mq.delete();
    end else begin
      if (pick >= 0) begin
        m_iss_vld = 1'b1;
        m_iss     = mq[pick];
        if (m_iss.dd != 0) nb[m_iss.dd] = 1'b1;
        mq.delete(pick);
      end
      if (!was_busy) begin
        for (int s = 0; s < 2; s++) begin
          if (bus.in_vld[s]) begin
            e.ds   = bus.in_ds[6*s +: 6];
            e.dt   = bus.in_dt[6*s +: 6];
            e.dd   = bus.in_dd[6*s +: 6];
            e.mod  = bus.in_mod[9*s +: 9];
            e.info = bus.in_info[48*s +: 48];
            mq.push_back(e);
          end
        end
      end
    end
    mboard = nb;
  endtask

  task automatic applyStimulus(input logic [1:0] vld,
                               input logic [5:0] ds0, input logic [5:0] dt0, input logic [5:0] dd0, input logic [8:0] mod0,
                               input logic [5:0] ds1, input logic [5:0] dt1, input logic [5:0] dd1, input logic [8:0] mod1,
                               input logic [8:0] urdy, input logic wb, input logic [5:0] wbr, input logic fl);
    bus.in_vld   = vld;
    bus.in_ds    = {ds1, ds0};
    bus.in_dt    = {dt1, dt0};
    bus.in_dd    = {dd1, dd0};
    bus.in_mod   = {mod1, mod0};
    bus.in_info  = {$urandom(), $urandom(), $urandom()};
    bus.unit_rdy = urdy;
    bus.wb_vld   = wb;
    bus.wb_reg   = wbr;
    bus.flush    = fl;
  endtask

  // Compare every observable output with the reference model after an edge
  task automatic checkOutput();
    check("iss_vld", bus.iss_vld, m_iss_vld);
    if (m_iss_vld) begin
      check("iss_mod", bus.iss_mod, m_iss.mod);
      check("iss_ds", bus.iss_ds, m_iss.ds);
      check("iss_dt", bus.iss_dt, m_iss.dt);
      check("iss_dd", bus.iss_dd, m_iss.dd);
      check("iss_info", bus.iss_info, m_iss.info);
    end
    check("err", bus.err, merr);
    check("busy", bus.busy, mq.size() > DEPTH - 2);
  endtask

  task automatic step();
    modelStep();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic go(input logic [1:0] vld,
                    input logic [5:0] ds0, input logic [5:0] dt0, input logic [5:0] dd0, input logic [8:0] mod0,
                    input logic [5:0] ds1, input logic [5:0] dt1, input logic [5:0] dd1, input logic [8:0] mod1,
                    input logic [8:0] urdy, input logic wb, input logic [5:0] wbr, input logic fl);
    applyStimulus(vld, ds0, dt0, dd0, mod0, ds1, dt1, dd1, mod1, urdy, wb, wbr, fl);
    step();
  endtask

  task automatic idle();
    go(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, U, 0, 0, 0);
  endtask

  task automatic doReset();
    rstn = 1'b0;
    applyStimulus(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, U, 0, 0, 0);
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_iss_vld", bus.iss_vld, 0);
    check("rst_iss_fields", {bus.iss_mod, bus.iss_ds, bus.iss_dt, bus.iss_dd}, 0);
    check("rst_iss_info", bus.iss_info, 0);
    check("rst_err", bus.err, 0);
    check("rst_busy", bus.busy, 0);
    rstn = 1'b1;
  endtask

  function automatic logic [5:0] rndReg();
    if ($urandom_range(3) == 0) return (6'd1 << FPR_BIT) | 6'($urandom_range(3));
    return 6'($urandom_range(7));
  endfunction

  // Random traffic: small register pool for frequent hazards, writebacks mostly drawn from outstanding registers
  task automatic randomPhase(input int ncyc);
    int          cand[$];
    logic        wb;
    logic [5:0]  wbr;
    for (int c = 0; c < ncyc; c++) begin
      cand.delete();
      for (int r = 1; r < 64; r++) if (mboard[r]) cand.push_back(r);
      wb  = 1'b0;
      wbr = '0;
      if (cand.size() > 0 && $urandom_range(2) == 0) begin
        wb  = 1'b1;
        wbr = 6'(cand[$urandom_range(cand.size() - 1)]);
      end else if ($urandom_range(40) == 0) begin
        wb  = 1'b1;
        wbr = 6'($urandom_range(63));
      end
      go(2'($urandom_range(3)),
         rndReg(), rndReg(), rndReg(), mods[$urandom_range(8)],
         rndReg(), rndReg(), rndReg(), mods[$urandom_range(8)],
         9'($urandom() | $urandom()), wb, wbr, $urandom_range(39) == 0);
    end
  endtask

  // Main sequence: reset, vector table, corner sequences, random traffic, summary
  initial begin
    int n;
    tests = 0;
    fails = 0;
    mods  = '{mod_b, mod_io, mod_mem, mod_alu, mod_mv, mod_fab, mod_fml, mod_fds, mod_fet};
    doReset();

    tbl[0]  = '{2'b01, 1, 2, 3, 0, 0, 0, mod_alu, 0, U, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{2'b00, 0, 0, 0, 0, 0, 0, 0, 0, U, 0, 0, 1, 3, 0, 0};
    tbl[2]  = '{2'b00, 0, 0, 0, 0, 0, 0, 0, 0, U, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{2'b00, 0, 0, 0, 0, 0, 0, 0, 0, U, 1, 3, 0, 0, 0, 0};
    tbl[4]  = '{2'b11, 1, 2, 3, 3, 1, 4, mod_alu, mod_alu, U, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{2'b00, 0, 0, 0, 0, 0, 0, 0, 0, U, 0, 0, 1, 3, 0, 0};
    tbl[6]  = '{2'b00, 0, 0, 0, 0, 0, 0, 0, 0, U, 0, 0, 0, 0, 0, 0};
    tbl[7]  = '{2'b00, 0, 0, 0, 0, 0, 0, 0, 0, U, 0, 0, 0, 0, 0, 0};
`ifdef ISSUE_SCHED_WB_BYPASS_EN
    tbl[8]  = '{2'b00, 0, 0, 0, 0, 0, 0, 0, 0, U, 1, 3, 1, 4, 0, 0};
    tbl[9]  = '{2'b00, 0, 0, 0, 0, 0, 0, 0, 0, U, 0, 0, 0, 0, 0, 0};
`else
    tbl[8]  = '{2'b00, 0, 0, 0, 0, 0, 0, 0, 0, U, 1, 3, 0, 0, 0, 0};
    tbl[9]  = '{2'b00, 0, 0, 0, 0, 0, 0, 0, 0, U, 0, 0, 1, 4, 0, 0};
`endif
    tbl[10] = '{2'b00, 0, 0, 0, 0, 0, 0, 0, 0, U, 1, 4, 0, 0, 0, 0};
    tbl[11] = '{2'b11, 8, 9, 10, 11, 0, 12, mod_alu, mod_mem, U, 0, 0, 0, 0, 0, 0};
    tbl[12] = '{2'b00, 0, 0, 0, 0, 0, 0, 0, 0, U & ~mod_alu, 0, 0, 1, 12, 0, 0};
    tbl[13] = '{2'b00, 0, 0, 0, 0, 0, 0, 0, 0, U, 0, 0, 1, 10, 0, 0};
    tbl[14] = '{2'b00, 0, 0, 0, 0, 0, 0, 0, 0, U, 1, 12, 0, 0, 0, 0};
    tbl[15] = '{2'b00, 0, 0, 0, 0, 0, 0, 0, 0, U, 1, 10, 0, 0, 0, 0};
    tbl[16] = '{2'b00, 0, 0, 0, 0, 0, 0, 0, 0, U, 1, 7, 0, 0, 1, 0};
    tbl[17] = '{2'b00, 0, 0, 0, 0, 0, 0, 0, 0, U, 0, 0, 0, 0, 1, 0};

    for (int i = 0; i < 18; i++) begin
      go(tbl[i].vld, tbl[i].ds0, tbl[i].dt0, tbl[i].dd0, tbl[i].mod0,
         tbl[i].ds1, tbl[i].dt1, tbl[i].dd1, tbl[i].mod1, tbl[i].urdy, tbl[i].wb, tbl[i].wbr, 1'b0);
      check($sformatf("tbl%0d_iss_vld", i), bus.iss_vld, tbl[i].e_iss);
      if (tbl[i].e_iss) check($sformatf("tbl%0d_iss_dd", i), bus.iss_dd, tbl[i].e_dd);
      check($sformatf("tbl%0d_err", i), bus.err, tbl[i].e_err);
      check($sformatf("tbl%0d_busy", i), bus.busy, tbl[i].e_busy);
    end

    // Fill the buffer with readers of an outstanding r5; further decode must be ignored
    doReset();
    go(2'b01, 0, 0, 5, mod_alu, 0, 0, 0, 0, U, 0, 0, 0);
    idle();
    check("busyseq_writer_dd", bus.iss_dd, 5);
    go(2'b11, 5, 0, 20, mod_alu, 5, 0, 21, mod_alu, U, 0, 0, 0);
    check("busyseq_half_busy", bus.busy, 0);
    go(2'b11, 5, 0, 22, mod_alu, 5, 0, 23, mod_alu, U, 0, 0, 0);
    check("busyseq_full_busy", bus.busy, 1);
    go(2'b11, 0, 0, 30, mod_alu, 0, 0, 31, mod_alu, U, 0, 0, 0);
    check("busyseq_ignored_busy", bus.busy, 1);
    check("busyseq_ignored_iss", bus.iss_vld, 0);
    go(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, U, 1, 5, 0);
    n = 0;
    for (int i = 0; i < 7; i++) begin
      if (bus.iss_vld) begin
        check($sformatf("busyseq_order%0d", n), bus.iss_dd, 6'(20 + n));
        n++;
      end
      if (i < 6) idle();
    end
    check("busyseq_issue_count", n, 4);

    // Flush with three waiting entries while one would have been picked that cycle
    doReset();
    go(2'b01, 0, 0, 6, mod_alu, 0, 0, 0, 0, U, 0, 0, 0);
    idle();
    go(2'b11, 0, 0, 13, mod_fet, 0, 0, 14, mod_fet, U & ~mod_fet, 0, 0, 0);
    go(2'b01, 0, 0, 15, mod_fet, 0, 0, 0, 0, U & ~mod_fet, 0, 0, 0);
    check("flush_pre_busy", bus.busy, 1);
    go(2'b01, 0, 0, 9, mod_alu, 0, 0, 0, 0, U, 0, 0, 1);
    check("flush_iss_vld", bus.iss_vld, 0);
    check("flush_busy", bus.busy, 0);
    idle();
    check("flush_after_iss", bus.iss_vld, 0);
    go(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, U, 1, 6, 0);
    check("flush_board_kept", bus.err, 0);
    go(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, U, 1, 13, 0);
    check("flush_no_set", bus.err, 1);

    // Reset while an issue is in flight and an entry still waits
    go(2'b11, 0, 0, 1, mod_alu, 0, 0, 2, mod_alu, U, 0, 0, 0);
    idle();
    check("midrst_pre_iss", bus.iss_vld, 1);
    doReset();
    for (int i = 0; i < 3; i++) begin
      idle();
      check($sformatf("midrst_quiet%0d", i), bus.iss_vld, 0);
    end

    randomPhase(3000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/issue_sched.md
ISSUE_SCHED -- requirements
Module: issue_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 4: wait-buffer entries (power of two, >=2).
REQ-002 SHALL have parameter NMOD, default 9: one-hot functional-unit width (b, io, mem, alu, mv, fab, fml, fds, fet).
REQ-003 SHALL have parameter INFO_W, default 48: opaque payload width (ope, imm, opr, ctrl, pc).
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 rstn  in  1  reset; one clock; reset is synchronous and active-low.
REQ-006 in_vld  in  2  decoded slot valid; bit0 older than bit1.
REQ-007 in_ds, in_dt, in_dd  in  12 each  {slot1,slot0} 6-bit register ids ({fpr,gpr} index; 0 = none).
REQ-008 in_mod  in  2*NMOD  {slot1,slot0} one-hot unit select; in_info  in  2*INFO_W  payload.
REQ-009 busy  out  1  fewer than 2 free entries; decode holds its slots.
REQ-010 unit_rdy  in  NMOD  unit accepts an instruction this cycle.
REQ-011 wb_vld  in  1, wb_reg  in  6  writeback completing; clears scoreboard bit.
REQ-012 flush  in  1  branch mispredict/control hazard; discard all waiting entries.
REQ-013 iss_vld  out  1; iss_mod  out  NMOD; iss_ds, iss_dt, iss_dd  out  6 each; iss_info  out  INFO_W.
REQ-014 err  out  1  sticky: writeback to a register not marked busy.

Function
REQ-015 Buffer SHALL be an age-ordered shift queue: entry 0 oldest; issue of entry k shifts entries k+1.. down one.
REQ-016 When ~busy and ~flush, valid slots SHALL append in order (slot0 then slot1); slot1-only fills one entry; when busy, inputs SHALL be ignored.
REQ-017 busy SHALL be combinational from current count only (count > DEPTH-2), not from same-cycle issue.
REQ-018 Scoreboard board[63:0] SHALL mark registers with an issued, not-yet-written-back writer; bit 0 never set.
REQ-019 Entry k ready iff: ds, dt, dd bits clear in board; unit_rdy & mod nonzero; no older entry j<k has dd_j (nonzero) equal to ds_k, dt_k or dd_k (RAW/WAW); no older entry reads dd_k (WAR).
REQ-020 At most one issue per cycle: oldest ready entry.
REQ-021 Issue SHALL be registered: entry ready in cycle t -> iss_vld=1 with its fields in t+1, for exactly one cycle; board bit dd set in t+1.
REQ-022 wb_vld in cycle t SHALL clear board[wb_reg] in t+1; wb_reg=0 no effect.
REQ-023 Same-cycle set (issue) and clear (wb) of one register: set SHALL win.
REQ-024 err SHALL set in t+1 when wb_vld, wb_reg!=0 and board[wb_reg]=0; cleared only by reset.
REQ-025 flush SHALL empty buffer next cycle, suppress any issue selected that cycle, drop same-cycle inputs; board SHALL be kept (in-flight ops still write back).

Reset
REQ-026 On rstn=0: count=0, board=0, err=0, iss_vld=0, all iss_* fields 0, busy=0 following cycle.
REQ-027 Reset mid-operation SHALL discard entries and in-flight issue without regard to handshake state.

Configuration
REQ-028 Macro ISSUE_SCHED_WB_BYPASS_EN defined: register cleared by wb_vld in cycle t counts as not busy for readiness in t (issue visible t+1).
REQ-029 Without it: such register ready no earlier than t+1 (issue visible t+2).

Structure
REQ-030 Shared package SHALL hold mod_* one-hot constants, register-id width 6, FPR bit position 5.
REQ-031 Readiness/oldest-select logic SHALL be a sub-module issue_sched_pick (combinational, DEPTH-parametrised); queue and scoreboard remain in issue_sched.

Verification
REQ-032 Enqueue add r3<-r1,r2 (alu) with unit_rdy all 1 -> iss_vld cycle 2 after enqueue edge, board[3]=1.
REQ-033 add r3<-r1,r2 then sub r4<-r3,r1 same cycle -> sub not issued until wb_reg=3; then iss t+2 (t+1 with bypass).
REQ-034 Fill 4 entries all dependent on r5 busy -> busy=1, in_vld=2'b11 ignored, count stays 4.
REQ-035 Two independent entries, unit_rdy[alu]=0 for older -> younger mem op issues first.
REQ-036 flush with 3 entries and same-cycle in_vld=2'b01 -> count 0, iss_vld=0 next cycle, board unchanged.
REQ-037 wb_vld, wb_reg=7 with board[7]=0 -> err=1 and remains 1 until rstn=0.
